mcm_arbiter: RTL
================

// Module: mcm_arbiter
// PURPOSE
//   Parametrised arbiter between NUM_CH cache clients and the shared multi-cycle memory.
//   Successor to the fixed two-way ISTALL/DSTALL mux in the CPU.
//   Grants one client at a time and runs either a BURST_LEN-word line fill or a single-word write-through.
//   Steers returned beats to the granted client.
//   Sits between the I/D caches (plus future clients) and the memory model.
// PARAMETERS
//   NUM_CH     2   number of clients; ch0 = ICACHE, ch1 = DCACHE (2..8)
//   ADDR_W     16  byte address width
//   DATA_W     16  memory word width
//   BURST_LEN  8   words per line fill, power of 2 (2..16)
// PORTS
//   clk        in   1               single clock, rising edge
//   rst        in   1               asynchronous, active-high reset
//   ch_req     in   NUM_CH          client request; held until ch_done
//   ch_we      in   NUM_CH          1 = single-word write, 0 = line fill
//   ch_addr    in   NUM_CH*ADDR_W   per-client byte address (packed, ch0 in LSBs)
//   ch_wdata   in   NUM_CH*DATA_W   per-client write data
//   ch_gnt     out  NUM_CH          one-hot grant, held for whole transaction
//   ch_rvalid  out  NUM_CH          beat valid to granted client
//   ch_beat    out  $clog2(BURST_LEN)  index of current returned beat
//   ch_rdata   out  DATA_W          returned word (shared bus, qualified by ch_rvalid)
//   ch_done    out  NUM_CH          1-cycle pulse: transaction complete
//   mem_en     out  1               memory enable
//   mem_wr     out  1               memory write strobe
//   mem_addr   out  ADDR_W          memory byte address
//   mem_wdata  out  DATA_W          memory write data
//   mem_rdata  in   DATA_W          memory read data
//   mem_valid  in   1               memory read data valid (pipelined, fixed unknown latency)
//   err_stray  out  1               1-cycle pulse: mem_valid with no read outstanding
// BEHAVIOUR
//   Reset
//     All outputs 0; FSM = IDLE; issue and return counters = 0; RR pointer = 0.
//   FSM: IDLE -> (READ | WRITE)
//     IDLE: when any ch_req, pick a winner and register ch_gnt on the next edge.
//       A request seen at cycle t gives gnt at t+1 and the first mem_en at t+1.
//       Winner's ch_we selects WRITE, else READ.
//     READ, issue: base = addr & ~(2*BURST_LEN-1).
//       Issue BURST_LEN reads, one per cycle, at base+2*i (i=0..BURST_LEN-1).
//       mem_en=1, mem_wr=0 during issue.
//     READ, return: each mem_valid drives ch_rvalid[gnt]=1, ch_rdata=mem_rdata, ch_beat=return count, same cycle (combinational).
//       Return count increments; issue and return may overlap.
//       On the BURST_LEN-th valid: ch_done[gnt] pulses, gnt drops next cycle, FSM -> IDLE.
//     WRITE: one cycle with mem_en=1, mem_wr=1, mem_addr=ch_addr, mem_wdata=ch_wdata.
//       ch_done pulses the following cycle; -> IDLE.
//     Back-to-back: the IDLE cycle after a done is mandatory.
//       Min gap between transactions = 1 cycle.
//   Arbitration
//     Fixed priority, lowest index wins (ICACHE over DCACHE).
//   Boundaries
//     Client drops ch_req mid-transaction: ignored; transaction completes, done still pulses.
//     mem_valid in IDLE or WRITE: dropped, err_stray=1.
//     More valids than issued reads: same handling, dropped with err_stray=1.
//     Async reset mid-burst: immediate return to reset state; in-flight beats are lost.
//     Address wrap at 2^ADDR_W: base alignment means a burst never wraps.
//     Simultaneous requests: exactly one grant, never more than one ch_gnt bit.
// CONFIGURATION
//   MCM_ARB_ROUND_ROBIN_EN defined:
//     Rotating priority; the RR pointer moves to (winner+1) mod NUM_CH when done pulses.
//     Any continuously requesting client is granted within NUM_CH transactions.
//   Undefined: fixed priority as above; RR pointer logic is not synthesised.
// STRUCTURE
//   Package mcm_arb_pkg:
//     FSM state enum {IDLE, READ, WRITE}.
//     BEAT_W = $clog2(BURST_LEN) helper.
//     Channel index constants CH_ICACHE=0, CH_DCACHE=1.
//   Sub-module mcm_arb_pick: combinational req + pointer -> one-hot winner.
//     Holds both the fixed and RR forms under the macro.
//   Top level: FSM, issue/return counters, output steering.
// TESTING
//   Reset: rst=1 mid-burst -> all outputs 0 the same cycle; after release a new req works cleanly.
//   Line fill, BURST_LEN=8, ch1 addr 0x1236:
//     mem_addr 0x1230..0x123E in 8 consecutive cycles.
//     8 ch_rvalid[1] pulses with ch_beat 0..7; ch_done[1] on the 8th.
//   Write, ch1 we=1 addr 0x0042 data 0xBEEF:
//     One cycle mem_en=mem_wr=1 with that addr/data; ch_done[1] next cycle; no rvalid.
//   Contention, ch0 and ch1 req together, fixed priority:
//     ch0 served first, ch1 granted in the cycle after the IDLE gap.
//     RR build with both held for 4 transactions -> grants 0,1,0,1.
//   Stray and latency: mem_valid in IDLE -> err_stray=1, no ch_rvalid.
//     With memory latency 4, beats still arrive in order and done fires on the 8th valid.

Source files
------------

// File: rtl/mcm_arb_pkg.sv
// Shared types and helpers for the multi-client memory arbiter.
// Optional feature macro: MCM_ARB_ROUND_ROBIN_EN (rotating priority).
package mcm_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } arb_state_e;

  // Client channel assignment
  localparam int CH_ICACHE = 0;
  localparam int CH_DCACHE = 1;

  // Width of the beat index for a burst of burst_len words
  function automatic int beat_w(input int burst_len);
    return $clog2(burst_len);
  endfunction

endpackage

// File: rtl/mcm_arb_pick.sv
// Combinational winner selection: request vector -> one-hot winner.
// MCM_ARB_ROUND_ROBIN_EN defined: search starts at ptr_i and wraps.
// Undefined: lowest requesting index wins and no pointer port exists.
module mcm_arb_pick #(
  parameter int NUM_CH = 2,
  parameter int PTR_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
`ifdef MCM_ARB_ROUND_ROBIN_EN
  input  logic [PTR_W-1:0]  ptr_i,
`endif
  output logic [NUM_CH-1:0] win_o
);

`ifdef MCM_ARB_ROUND_ROBIN_EN
  localparam logic [PTR_W:0] NUM_L = (PTR_W+1)'(NUM_CH);

  // Rotating search: first requester at or after the pointer wins
  always_comb begin
    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    win_o = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (sum >= NUM_L) begin
        sum = sum - NUM_L;
      end else begin
        sum = sum;
      end
      idx = sum[PTR_W-1:0];
      if (req_i[idx] && !found) begin
        win_o[idx] = 1'b1;
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end
`else
  // Fixed priority: isolate the lowest set request bit
  always_comb begin
    win_o = req_i & (~req_i + NUM_CH'(1));
  end
`endif

endmodule

// File: rtl/mcm_arbiter.sv
// Arbiter between NUM_CH cache clients and a shared pipelined memory.
// Grants one client at a time for a BURST_LEN-word aligned line fill or a
// single-word write, and steers returned beats to the granted client.
// Optional feature macro: MCM_ARB_ROUND_ROBIN_EN (rotating priority).
module mcm_arbiter
  import mcm_arb_pkg::*;
#(
  parameter int  NUM_CH    = 2,
  parameter int  ADDR_W    = 16,
  parameter int  DATA_W    = 16,
  parameter int  BURST_LEN = 8,
  localparam int BEAT_W    = beat_w(BURST_LEN)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        ch_req_i,
  input  logic [NUM_CH-1:0]        ch_we_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata_i,
  output logic [NUM_CH-1:0]        ch_gnt_o,
  output logic [NUM_CH-1:0]        ch_rvalid_o,
  output logic [BEAT_W-1:0]        ch_beat_o,
  output logic [DATA_W-1:0]        ch_rdata_o,
  output logic [NUM_CH-1:0]        ch_done_o,
  output logic                     mem_en_o,
  output logic                     mem_wr_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  input  logic                     mem_valid_i,
  output logic                     err_stray_o
);

  localparam int              PTR_W     = $clog2(NUM_CH);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(2*BURST_LEN-1);
  localparam logic [BEAT_W:0] LAST_BEAT = (BEAT_W+1)'(BURST_LEN-1);

  arb_state_e          state_q, state_d;
  logic [NUM_CH-1:0]   gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BEAT_W:0]     issue_q, issue_d;
  logic [BEAT_W:0]     ret_q, ret_d;
  logic                wdone_q, wdone_d;

  logic [NUM_CH-1:0]   win_s;
  logic                win_we_s;
  logic [ADDR_W-1:0]   win_addr_s;
  logic [DATA_W-1:0]   win_wdata_s;
  logic                issuing_s;
  logic                accept_s;
  logic                last_beat_s;

`ifdef MCM_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    gnt_idx_s;
`endif

  mcm_arb_pick #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req_i  (ch_req_i),
`ifdef MCM_ARB_ROUND_ROBIN_EN
    .ptr_i  (ptr_q),
`endif
    .win_o  (win_s)
  );

  // Mux the winner's command fields out of the packed client buses (one-hot AND-OR)
  always_comb begin
    win_we_s    = 1'b0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      win_we_s    = win_we_s | (ch_we_i[i] & win_s[i]);
      win_addr_s  = win_addr_s | (ch_addr_i[i*ADDR_W +: ADDR_W] & {ADDR_W{win_s[i]}});
      win_wdata_s = win_wdata_s | (ch_wdata_i[i*DATA_W +: DATA_W] & {DATA_W{win_s[i]}});
    end
  end

  // Read-path status: still issuing, and whether a returning beat is owed
  always_comb begin
    issuing_s   = (state_q == READ) && !issue_q[BEAT_W];
    accept_s    = mem_valid_i && (state_q == READ) && (ret_q < issue_q);
    last_beat_s = accept_s && (ret_q == LAST_BEAT);
  end

  // FSM next state, grant and counter updates
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    issue_d = issue_q;
    ret_d   = ret_q;
    wdone_d = wdone_q;
    case (state_q)
      IDLE: begin
        if (wdone_q) begin
          // write-done cycle: grant released, no arbitration yet
          gnt_d   = '0;
          wdone_d = 1'b0;
        end else if (|ch_req_i) begin
          gnt_d   = win_s;
          wdata_d = win_wdata_s;
          issue_d = '0;
          ret_d   = '0;
          if (win_we_s) begin
            state_d = WRITE;
            addr_d  = win_addr_s;
          end else begin
            state_d = READ;
            addr_d  = win_addr_s & ~LINE_MASK;
          end
        end else begin
          gnt_d = '0;
        end
      end
      READ: begin
        if (issuing_s) begin
          issue_d = issue_q + (BEAT_W+1)'(1);
        end else begin
          issue_d = issue_q;
        end
        if (accept_s) begin
          ret_d = ret_q + (BEAT_W+1)'(1);
          if (last_beat_s) begin
            state_d = IDLE;
            gnt_d   = '0;
          end else begin
            state_d = READ;
          end
        end else begin
          ret_d = ret_q;
        end
      end
      WRITE: begin
        state_d = IDLE;
        wdone_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        wdone_d = 1'b0;
      end
    endcase
  end

  // State and transaction registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      issue_q <= '0;
      ret_q   <= '0;
      wdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      issue_q <= issue_d;
      ret_q   <= ret_d;
      wdone_q <= wdone_d;
    end
  end

`ifdef MCM_ARB_ROUND_ROBIN_EN
  // Pointer advances past the client whose transaction just completed
  always_comb begin
    gnt_idx_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_q[i]) begin
        gnt_idx_s = PTR_W'(i);
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
    end
    if (|ch_done_o) begin
      if (gnt_idx_s == PTR_W'(NUM_CH-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx_s + PTR_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= PTR_W'(CH_ICACHE);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Output steering; everything is derived from registered state except the
  // return path, which follows mem_valid in the same cycle
  always_comb begin
    ch_gnt_o    = gnt_q;
    ch_rvalid_o = '0;
    ch_beat_o   = '0;
    ch_rdata_o  = '0;
    ch_done_o   = '0;
    mem_en_o    = issuing_s || (state_q == WRITE);
    mem_wr_o    = (state_q == WRITE);
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    err_stray_o = mem_valid_i && !accept_s;
    if (accept_s) begin
      ch_rvalid_o = gnt_q;
      ch_beat_o   = ret_q[BEAT_W-1:0];
      ch_rdata_o  = mem_rdata_i;
    end else begin
      ch_rvalid_o = '0;
    end
    if (last_beat_s || ((state_q == IDLE) && wdone_q)) begin
      ch_done_o = gnt_q;
    end else begin
      ch_done_o = '0;
    end
    if (issuing_s) begin
      // base is line aligned, so OR-ing the word offset never carries
      mem_addr_o = addr_q | ADDR_W'({issue_q[BEAT_W-1:0], 1'b0});
    end else if (state_q == WRITE) begin
      mem_addr_o  = addr_q;
      mem_wdata_o = wdata_q;
    end else begin
      mem_addr_o = '0;
    end
  end

endmodule
